// File: rtl/transport_ctrl_mslot_pkg.sv
// ============================================================================
// Module : transport_pkg  (transport_ctrl_mslot shared types and helpers)
// Rev    : 1.0
// ============================================================================
`default_nettype none
package transport_pkg;

    typedef enum logic [2:0] {
        P_STOP  = 3'b000,
        P_RUN   = 3'b010,
        P_PAUSE = 3'b011,
        R_STOP  = 3'b100,
        INIT    = 3'b101,
        R_RUN   = 3'b110,
        R_PAUSE = 3'b111
    } state_t;

    typedef struct packed {
        logic       slow;
        logic [3:0] mag;
    } speed_t;

    localparam speed_t c_SPEED_1X = '{slow: 1'b0, mag: 4'd1};

    // Playback states are the ones with bit 2 clear.
    function automatic logic is_play(input state_t s);
        return !s[2];
    endfunction

    function automatic speed_t next_speed(input speed_t cur, input logic fast,
                                          input logic slow, input logic [3:0] max);
        speed_t nxt;
        nxt = cur;
        if (fast && !slow) begin
            if (!cur.slow)
                nxt.mag = (cur.mag >= max) ? max : cur.mag + 4'd1;
            else if (cur.mag <= 4'd2)
                nxt = c_SPEED_1X;
            else
                nxt.mag = cur.mag - 4'd1;
        end else if (slow && !fast) begin
            if (cur.slow || cur.mag == 4'd1) begin
                nxt.slow = 1'b1;
                nxt.mag  = (cur.mag >= max) ? max : cur.mag + 4'd1;
            end else if (cur.mag <= 4'd2) begin
                nxt = c_SPEED_1X;
            end else begin
                nxt.mag = cur.mag - 4'd1;
            end
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/transport_ctrl_mslot_if.sv
// ============================================================================
// Module : transport_ctrl_mslot_if  (key/I2S/SRAM-side bundle of the controller)
// Rev    : 1.0
// ============================================================================
`default_nettype none
interface transport_ctrl_mslot_if
    import transport_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int N_SLOTS = 4
);
    localparam int c_SLOT_W = $clog2(N_SLOTS);

    logic                       init_done;
    logic                       key_play;
    logic                       key_stop;
    logic                       key_fast;
    logic                       key_slow;
    logic                       mode;
    logic [c_SLOT_W-1:0]        slot_sel;
    logic                       rec_valid;
    logic                       play_adv;
    state_t                     state;
    logic [c_SLOT_W-1:0]        cur_slot;
    logic                       speed_slow;
    logic [3:0]                 speed_mag;
    logic                       rec_grant;
    logic [ADDR_W-1:0]          rec_addr;
    logic [ADDR_W-1:0]          play_addr;
    logic [ADDR_W-c_SLOT_W:0]   slot_len;

    modport slave (
        input  init_done, key_play, key_stop, key_fast, key_slow, mode,
               slot_sel, rec_valid, play_adv,
        output state, cur_slot, speed_slow, speed_mag, rec_grant,
               rec_addr, play_addr, slot_len
    );

    modport master (
        output init_done, key_play, key_stop, key_fast, key_slow, mode,
               slot_sel, rec_valid, play_adv,
        input  state, cur_slot, speed_slow, speed_mag, rec_grant,
               rec_addr, play_addr, slot_len
    );
endinterface
`default_nettype wire

// File: rtl/transport_ctrl_mslot_speed_step_gen.sv
// ============================================================================
// Module : speed_step_gen  (per-play_adv offset step with slow-down divider)
// Rev    : 1.0
// ============================================================================
`default_nettype none
module speed_step_gen
    import transport_pkg::*;
(
    input  wire         i_clk,
    input  wire         i_rst,
    input  wire         i_clear,
    input  wire         i_adv,
    input  wire speed_t i_speed,
    output logic [3:0]  o_step
);
    logic [3:0] r_div;
    logic       w_hit;

    // >= rather than == so a speed change mid-count cannot strand the divider.
    assign w_hit = (r_div >= i_speed.mag - 4'd1);

    always_comb begin
        o_step = 4'd0;
        if (i_adv)
            o_step = i_speed.slow ? {3'd0, w_hit} : i_speed.mag;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear)
            r_div <= 4'd0;
        else if (i_adv)
            r_div <= (!i_speed.slow || w_hit) ? 4'd0 : r_div + 4'd1;
    end
endmodule
`default_nettype wire

// File: rtl/transport_ctrl_mslot.sv
// ============================================================================
// Module : transport_ctrl_mslot  (multi-slot play/record transport, speed, SRAM addressing)
// Option : LOOP_PLAY_EN wraps playback at slot end instead of stopping.   Rev : 1.0
// ============================================================================
`default_nettype none
module transport_ctrl_mslot
    import transport_pkg::*;
#(
    parameter int ADDR_W     = 20,
    parameter int N_SLOTS    = 4,
    parameter int MAX_FACTOR = 8
) (
    input  wire                    clk,
    input  wire                    rst,
    transport_ctrl_mslot_if.slave  bus
);
    localparam int         c_SLOT_W = $clog2(N_SLOTS);
    localparam int         c_OFF_W  = ADDR_W - c_SLOT_W;
    localparam int         c_LEN_W  = c_OFF_W + 1;
    localparam int         c_SUM_W  = c_OFF_W + 5;
    localparam logic [3:0] c_MAX    = 4'(MAX_FACTOR);

    state_t              r_state;
    logic                r_mode;
    logic [c_SLOT_W-1:0] r_slot;
    speed_t              r_speed;
    logic [c_OFF_W-1:0]  r_rec_off;
    logic [c_OFF_W-1:0]  r_play_off;
    logic [c_LEN_W-1:0]  r_len [N_SLOTS];

    logic                w_rec_grant;
    logic                w_rec_last;
    logic                w_adv;
    logic                w_play_end;
    logic                w_play_stop;
    logic [c_LEN_W-1:0]  w_cur_len;
    logic [3:0]          w_step;
    logic [c_SUM_W-1:0]  w_play_sum;
    logic [c_OFF_W-1:0]  w_play_next;

    assign w_cur_len   = r_len[r_slot];
    assign w_rec_grant = bus.rec_valid && (r_state == R_RUN);
    assign w_rec_last  = w_rec_grant && (r_rec_off == {c_OFF_W{1'b1}});
    assign w_adv       = bus.play_adv && (r_state == P_RUN);

    speed_step_gen u_step (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clear (r_state == P_STOP),
        .i_adv   (w_adv),
        .i_speed (r_speed),
        .o_step  (w_step)
    );

    assign w_play_sum = c_SUM_W'(r_play_off) + c_SUM_W'(w_step);
    assign w_play_end = w_adv && (w_play_sum >= c_SUM_W'(w_cur_len));
`ifdef LOOP_PLAY_EN
    assign w_play_stop = 1'b0;
    assign w_play_next = w_play_end ? c_OFF_W'(w_play_sum - c_SUM_W'(w_cur_len))
                                    : c_OFF_W'(w_play_sum);
`else
    assign w_play_stop = w_play_end;
    assign w_play_next = w_play_end ? '0 : c_OFF_W'(w_play_sum);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= INIT;
            r_mode     <= 1'b1;
            r_slot     <= '0;
            r_speed    <= c_SPEED_1X;
            r_rec_off  <= '0;
            r_play_off <= '0;
            for (int i = 0; i < N_SLOTS; i++)
                r_len[i] <= '0;
        end else begin
            r_mode  <= bus.mode;
            r_speed <= is_play(r_state) ? next_speed(r_speed, bus.key_fast, bus.key_slow, c_MAX)
                                        : c_SPEED_1X;

            if (r_state == P_STOP || r_state == R_STOP)
                r_slot <= bus.slot_sel;

            // Record offset only survives inside an active take (RUN/PAUSE).
            if (r_state == R_RUN || r_state == R_PAUSE) begin
                if (w_rec_grant) begin
                    r_rec_off     <= r_rec_off + 1'b1;
                    r_len[r_slot] <= c_LEN_W'(r_rec_off) + 1'b1;
                end
            end else begin
                r_rec_off <= '0;
            end

            case (r_state)
                INIT: if (bus.init_done) r_state <= r_mode ? R_STOP : P_STOP;
                P_STOP: begin
                    r_play_off <= '0;
                    if (r_mode)
                        r_state <= R_STOP;
                    else if (bus.key_play && w_cur_len != '0)
                        r_state <= P_RUN;
                end
                P_RUN: begin
                    if (w_adv)
                        r_play_off <= w_play_next;
                    if (bus.key_stop) begin
                        r_state    <= P_STOP;
                        r_play_off <= '0;
                    end else if (w_play_stop) begin
                        r_state <= P_STOP;
                    end else if (bus.key_play) begin
                        r_state <= P_PAUSE;
                    end
                end
                P_PAUSE: begin
                    if (r_mode) begin
                        r_state <= R_STOP;
                    end else if (bus.key_stop) begin
                        r_state    <= P_STOP;
                        r_play_off <= '0;
                    end else if (bus.key_play) begin
                        r_state <= P_RUN;
                    end
                end
                R_STOP: begin
                    if (!r_mode) begin
                        r_state    <= P_STOP;
                        r_play_off <= '0;
                    end else if (bus.key_play) begin
                        r_state <= R_RUN;
                    end
                end
                R_RUN: begin
                    if (w_rec_last || bus.key_stop)
                        r_state <= R_STOP;
                    else if (bus.key_play)
                        r_state <= R_PAUSE;
                end
                R_PAUSE: begin
                    if (!r_mode) begin
                        r_state    <= P_STOP;
                        r_play_off <= '0;
                    end else if (bus.key_stop) begin
                        r_state <= R_STOP;
                    end else if (bus.key_play) begin
                        r_state <= R_RUN;
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign bus.state      = r_state;
    assign bus.cur_slot   = r_slot;
    assign bus.speed_slow = r_speed.slow;
    assign bus.speed_mag  = r_speed.mag;
    assign bus.rec_grant  = w_rec_grant;
    assign bus.rec_addr   = {r_slot, r_rec_off};
    assign bus.play_addr  = {r_slot, r_play_off};
    assign bus.slot_len   = w_cur_len;
endmodule
`default_nettype wire
